// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and helpers for the FIFO push arbiter
// Contents:
//   arb_state_t   arbiter lock state (ARB_IDLE / ARB_LOCK)
//   STAT_W        width of each per-requester grant statistics counter
//   credit_width  bits needed to hold a credit count of 0..depth
package fifo_arb_pkg;

  typedef enum logic {ARB_IDLE = 1'b0, ARB_LOCK = 1'b1} arb_state_t;

  localparam int STAT_W = 16;

  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_push_arb_rr_prio_pick.sv
// rtl/fifo_push_arb_rr_prio_pick.sv - combinational round-robin priority picker
// Ports:
//   req    in  N   request vector
//   ptr    in  PW  index with highest priority this cycle
//   pick   out N   one-hot winner (zero when no request)
//   idx    out PW  index of the winner (0 when no request)
//   valid  out 1   at least one request was set
module rr_prio_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [PW-1:0] idx,
  output logic          valid
);

  logic [PW:0]   pos;
  logic [PW-1:0] pos_w;

  // Scan ptr, ptr+1, ... wrapping at N; the first set request wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = '0;
    pos_w = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + (PW+1)'(i);
      if (pos >= (PW+1)'(N)) begin
        pos = pos - (PW+1)'(N);
      end
      pos_w = pos[PW-1:0];
      if (!valid && req[pos_w]) begin
        valid = 1'b1;
        idx   = pos_w;
      end
    end
  end

  assign pick = valid ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;

endmodule

// File: rtl/fifo_push_arb.sv
// rtl/fifo_push_arb.sv - round-robin credit-based arbiter for one FIFO push port
// Optional feature macro: FIFO_PUSH_ARB_STATS_EN (adds grant_cnt statistics output)
// Ports:
//   clk         in  1      clock, rising edge
//   rst         in  1      asynchronous reset, active-high
//   req         in  N      per-requester beat request, held until granted
//   req_data    in  N*DW   requester i data in [i*DW +: DW]
//   gnt         out N      one-hot or zero, combinational beat accept
//   fifo_pop    in  1      consumer pop (snooped)
//   fifo_empty  in  1      FIFO empty flag (snooped)
//   fifo_push   out 1      registered push to the FIFO
//   fifo_wdata  out DW     registered write data to the FIFO
//   grant_cnt   out N*16   saturating per-requester grant counts (macro only)
module fifo_push_arb
  import fifo_arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int DW        = 16,
  parameter int DEPTH     = 4,
  parameter int BURST_LEN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  input  logic [N*DW-1:0]   req_data,
  output logic [N-1:0]      gnt,
  input  logic              fifo_pop,
  input  logic              fifo_empty,
`ifdef FIFO_PUSH_ARB_STATS_EN
  output logic [N*STAT_W-1:0] grant_cnt,
`endif
  output logic              fifo_push,
  output logic [DW-1:0]     fifo_wdata
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = credit_width(DEPTH);
  localparam int BW = $clog2(BURST_LEN + 1);

  arb_state_t    state, state_n;
  logic [PW-1:0] ptr, ptr_n;
  logic [PW-1:0] owner, owner_n;
  logic [BW-1:0] beats, beats_n;
  logic [CW-1:0] credit, credit_n;

  logic          has_credit;
  logic          owner_req;
  logic          owner_hold;
  logic [PW-1:0] pick_ptr;
  logic [N-1:0]  pick_oh;
  logic [PW-1:0] pick_idx;
  logic          pick_valid;
  logic          grant_valid;
  logic [PW-1:0] grant_idx;
  logic [DW-1:0] win_data;
  logic          credit_dec;
  logic          credit_inc;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    return (i == PW'(N - 1)) ? '0 : i + 1'b1;
  endfunction

  assign has_credit = (credit != '0);
  assign owner_req  = req[owner];
  // Owner still requesting: the lock holds, even if credit blocks the beat.
  assign owner_hold = (state == ARB_LOCK) && owner_req;

  // On release the scan starts just past the old owner, so the fresh
  // arbitration happens in the same cycle as the drop (no bubble).
  assign pick_ptr = (state == ARB_LOCK) ? next_idx(owner) : ptr;

  rr_prio_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .pick  (pick_oh),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Grant decision shared by the next-state and output processes.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = owner;
    if (owner_hold) begin
      grant_valid = has_credit;
      grant_idx   = owner;
    end else begin
      grant_valid = has_credit && pick_valid;
      grant_idx   = pick_idx;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ARB_IDLE;
      ptr    <= '0;
      owner  <= '0;
      beats  <= '0;
      credit <= CW'(DEPTH);
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      owner  <= owner_n;
      beats  <= beats_n;
      credit <= credit_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    beats_n = beats;
    if (owner_hold) begin
      if (grant_valid) begin
        beats_n = beats + 1'b1;
        if (beats_n == BW'(BURST_LEN)) begin
          ptr_n   = next_idx(owner);
          state_n = ARB_IDLE;
        end
      end
    end else begin
      if (state == ARB_LOCK) begin
        ptr_n   = next_idx(owner);
        state_n = ARB_IDLE;
      end
      if (grant_valid) begin
        owner_n = grant_idx;
        beats_n = BW'(1);
        if (BURST_LEN == 1) begin
          ptr_n   = next_idx(grant_idx);
          state_n = ARB_IDLE;
        end else begin
          state_n = ARB_LOCK;
        end
      end
    end
  end

  // Output logic: gnt is held low for the whole time reset is asserted.
  always_comb begin
    gnt = '0;
    if (grant_valid && !rst) begin
      gnt[grant_idx] = 1'b1;
    end
  end

  // Credit tracks free FIFO slots; a simultaneous beat and pop cancel out.
  assign credit_dec = |gnt;
  assign credit_inc = fifo_pop && !fifo_empty;

  always_comb begin
    credit_n = credit;
    case ({credit_dec, credit_inc})
      2'b10:   credit_n = credit - 1'b1;
      2'b01:   credit_n = credit + 1'b1;
      default: credit_n = credit;
    endcase
  end

  assign win_data = req_data[grant_idx*DW +: DW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_push  <= 1'b0;
      fifo_wdata <= '0;
    end else begin
      fifo_push <= |gnt;
      if (|gnt) begin
        fifo_wdata <= win_data;
      end
    end
  end

`ifdef FIFO_PUSH_ARB_STATS_EN
  logic [STAT_W-1:0] cnt [N];

  for (genvar g = 0; g < N; g++) begin : g_stats
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt[g] <= '0;
      end else if (gnt[g] && (cnt[g] != {STAT_W{1'b1}})) begin
        cnt[g] <= cnt[g] + 1'b1;
      end
    end
    assign grant_cnt[g*STAT_W +: STAT_W] = cnt[g];
  end
`endif

  // More credit than FIFO slots means the pop/empty snoop is inconsistent.
  a_credit_max : assert property (@(posedge clk) disable iff (rst) credit <= CW'(DEPTH))
    else $error("credit above DEPTH");

endmodule
